// File: rtl/ram_burst_reader_pkg.sv
// Shared types and helpers for the RAM burst reader family.
package ram_burst_reader_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
    localparam int FIFO_DEPTH     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } burst_state_e;

    // A new read may only be issued if its data is guaranteed a FIFO slot
    // when it returns: words buffered plus words in flight stay below the
    // FIFO depth, or sit exactly at it while a word leaves this cycle.
    function automatic logic creditOk(input logic [1:0] fifoCount,
                                      input logic       inflight,
                                      input logic       popNow);
        logic [2:0] pending;
        pending = {1'b0, fifoCount} + {2'b00, inflight};
        return (pending < 3'(FIFO_DEPTH)) ||
               ((pending == 3'(FIFO_DEPTH)) && popNow);
    endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read port and output stream signals of the burst reader.
interface ram_burst_reader_if
    import ram_burst_reader_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH
);
    logic                  start;
    logic [addr_width-1:0] base_addr;
    logic [addr_width:0]   burst_len;
    logic                  busy;
    logic                  done;
    logic [addr_width-1:0] ram_addr;
    logic                  ram_en;
    logic [data_width-1:0] ram_data;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport slave (
        input  start, base_addr, burst_len, ram_data, out_ready,
        output busy, done, ram_addr, ram_en, out_data, out_valid, out_last
    );

    modport master (
        output start, base_addr, burst_len, ram_data, out_ready,
        input  busy, done, ram_addr, ram_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one cycle latency.
module dual_port_ram #(
    parameter int addr_width = 4,
    parameter int data_width = 8,
    parameter int depth      = 1 << addr_width
) (
    input  logic                  clk,
    input  logic                  port_en_0,
    input  logic                  we_0,
    input  logic [addr_width-1:0] addr_in_0,
    input  logic [data_width-1:0] data_in_0,
    input  logic                  port_en_1,
    input  logic [addr_width-1:0] addr_in_1,
    output logic [data_width-1:0] data_out_1
);
    logic [data_width-1:0] mem [depth];

    // Port 0 write into the array.
    always_ff @(posedge clk) begin
        if (port_en_0 && we_0) begin
            mem[addr_in_0] <= data_in_0;
        end
    end

    // Port 1 registered read; output holds when the port is disabled.
    always_ff @(posedge clk) begin
        if (port_en_1) begin
            data_out_1 <= mem[addr_in_1];
        end
    end
endmodule

// File: rtl/ram_burst_reader_fifo2.sv
// Two-entry registered FIFO buffering RAM read data for the output stream.
module ram_rd_fifo2 #(
    parameter int width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [width-1:0] pushData_i,
    input  logic             pop_i,
    output logic [width-1:0] popData_o,
    output logic [1:0]       count_o,
    output logic             valid_o
);
    logic [width-1:0] mem_q [2];
    logic             wrPtr_q, wrPtr_d;
    logic             rdPtr_q, rdPtr_d;
    logic [1:0]       count_q, count_d;
    logic             doPush, doPop;

    // Pointer and occupancy update; a push into a full FIFO is only taken
    // when a pop frees a slot in the same cycle.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        doPop   = pop_i && (count_q != 2'd0);
        doPush  = push_i && ((count_q != 2'd2) || doPop);
        if (doPush) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (doPop) begin
            rdPtr_d = ~rdPtr_q;
        end
        count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
    end

    // Storage and pointer registers; reset empties the FIFO and clears data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign popData_o = mem_q[rdPtr_q];
    assign count_o   = count_q;
    assign valid_o   = (count_q != 2'd0);
endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words onto a valid/ready output.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int depth      = 1 << addr_width
) (
    input  logic                clk,
    input  logic                rst,
    ram_burst_reader_if.slave   bus
);
    burst_state_e          state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [addr_width:0]   remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  inflightLast_q, inflightLast_d;
    logic                  done_q, done_d;
    logic                  issue;
    logic                  pop;
    logic                  fifoValid;
    logic [1:0]            fifoCount;
    logic [data_width:0]   headEntry;

    // Each FIFO entry carries the data word plus its end-of-burst flag.
    ram_rd_fifo2 #(.width(data_width + 1)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .pushData_i ({inflightLast_q, bus.ram_data}),
        .pop_i      (pop),
        .popData_o  (headEntry),
        .count_o    (fifoCount),
        .valid_o    (fifoValid)
    );

    assign pop = fifoValid && bus.out_ready;

    // Burst sequencing: latch the request, issue reads under credit, then
    // wait for the tagged final word to leave before signalling done.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remain_d       = remain_q;
        inflight_d     = 1'b0;
        inflightLast_d = 1'b0;
        done_d         = 1'b0;
        issue          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    remain_d = bus.burst_len;
                    if (bus.burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if ((remain_q != '0) && creditOk(fifoCount, inflight_q, pop)) begin
                    issue          = 1'b1;
                    addr_d         = addr_width'((int'(addr_q) + 1) % depth);
                    remain_d       = remain_q - (addr_width + 1)'(1);
                    inflight_d     = 1'b1;
                    inflightLast_d = (remain_q == (addr_width + 1)'(1));
                    if (remain_q == (addr_width + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && headEntry[data_width]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any burst and drops in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remain_q       <= remain_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.ram_en    = issue;
    assign bus.ram_addr  = addr_q;
    assign bus.out_valid = fifoValid;
    assign bus.out_data  = headEntry[data_width-1:0];
    assign bus.out_last  = fifoValid && headEntry[data_width];
endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader driving a real dual_port_ram.
module tb_ram_burst_reader;
    import ram_burst_reader_pkg::*;

    typedef struct {
        int base;
        int len;
        int readyMode;
        int restartAt;
        int expDoneCycle;
        int expLastData;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn;
    logic [3:0] wrAddr;
    logic [7:0] wrData;
    logic [7:0] ramDataOut;
    int         checkCount = 0;
    int         errorCount = 0;
    vec_t       vectors [8];

    ram_burst_reader_if bus ();

    assign bus.ram_data = ramDataOut;

    dual_port_ram u_ram (
        .clk        (clk),
        .port_en_0  (wrEn),
        .we_0       (wrEn),
        .addr_in_0  (wrAddr),
        .data_in_0  (wrData),
        .port_en_1  (bus.ram_en),
        .addr_in_1  (bus.ram_addr),
        .data_out_1 (ramDataOut)
    );

    ram_burst_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int base, input int len);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 4'(base);
        bus.burst_len = 5'(len);
    endtask

    task automatic runBurst(input vec_t v, input string tag);
        int   beats, issued, lastCount, doneCount, doneAt, firstValidAt;
        int   maxOut, enIdle, stallViol, lastData, busyAtDone;
        logic ready, prevStall, prevLast;
        logic [7:0] prevData;
        beats = 0; issued = 0; lastCount = 0; doneCount = 0; doneAt = -1;
        firstValidAt = -1; maxOut = 0; enIdle = 0; stallViol = 0;
        lastData = -1; busyAtDone = 0; prevStall = 1'b0; prevLast = 1'b0;
        prevData = 8'd0; ready = 1'b0;
        applyStimulus(v.base, v.len);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == v.restartAt) begin
                bus.start     = 1'b1;
                bus.base_addr = 4'd7;
                bus.burst_len = 5'd2;
            end
            case (v.readyMode)
                0:       ready = 1'b1;
                1:       ready = ((c % 3) == 2);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = ready;
            #1;
            if (issued - beats > maxOut) maxOut = issued - beats;
            if (bus.ram_en) begin
                issued++;
                if (!bus.busy) enIdle++;
            end
            if (c == 0 && v.len > 0) begin
                checkOutput({tag, ".busyAtE0"}, int'(bus.busy), 1);
                checkOutput({tag, ".ramEnAtE0"}, int'(bus.ram_en), 1);
            end
            if (prevStall && (!bus.out_valid || bus.out_data != prevData || bus.out_last != prevLast)) begin
                stallViol++;
            end
            if (bus.out_valid && firstValidAt < 0) firstValidAt = c;
            if (bus.out_valid && ready) begin
                checkOutput($sformatf("%s.data%0d", tag, beats), int'(bus.out_data), ((v.base + beats) % 16) + 1);
                checkOutput($sformatf("%s.last%0d", tag, beats), int'(bus.out_last), int'(beats == v.len - 1));
                if (bus.out_last) begin
                    lastCount++;
                    lastData = int'(bus.out_data);
                end
                beats++;
            end
            prevStall = bus.out_valid && !ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
            if (bus.done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt     = c;
                    busyAtDone = int'(bus.busy);
                end
            end
            if (doneAt >= 0 && c >= doneAt + 3) break;
        end
        checkOutput({tag, ".beats"}, beats, v.len);
        checkOutput({tag, ".ramEnCycles"}, issued, v.len);
        checkOutput({tag, ".lastCount"}, lastCount, (v.len > 0) ? 1 : 0);
        checkOutput({tag, ".donePulses"}, doneCount, 1);
        checkOutput({tag, ".busyAtDone"}, busyAtDone, 0);
        checkOutput({tag, ".ramEnWhileIdle"}, enIdle, 0);
        checkOutput({tag, ".stallStable"}, stallViol, 0);
        checkOutput({tag, ".outstandingLe2"}, int'(maxOut <= 2), 1);
        if (v.expDoneCycle >= 0) checkOutput({tag, ".doneCycle"}, doneAt, v.expDoneCycle);
        if (v.len > 0) checkOutput({tag, ".lastData"}, lastData, v.expLastData);
        if (v.readyMode == 0 && v.len > 0) checkOutput({tag, ".firstValid"}, firstValidAt, 2);
    endtask

    initial begin
        // base, len, readyMode(0 always,1 one-in-three,2 random), restartAt, doneCycle, lastData
        vectors[0] = '{0, 16, 0, -1, 18, 16};
        vectors[1] = '{14, 4, 0, -1, 6, 2};
        vectors[2] = '{0, 8, 1, -1, -1, 8};
        vectors[3] = '{0, 8, 2, -1, -1, 8};
        vectors[4] = '{5, 0, 0, -1, 0, 0};
        vectors[5] = '{3, 6, 0, 2, 8, 9};
        vectors[6] = '{15, 1, 0, -1, 3, 16};
        vectors[7] = '{10, 16, 1, -1, -1, 10};

        rst = 1'b1;
        wrEn = 1'b0; wrAddr = 4'd0; wrData = 8'd0;
        bus.start = 1'b1; bus.base_addr = 4'd3; bus.burst_len = 5'd4; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busy", int'(bus.busy), 0);
        checkOutput("reset.done", int'(bus.done), 0);
        checkOutput("reset.ramEn", int'(bus.ram_en), 0);
        checkOutput("reset.ramAddr", int'(bus.ram_addr), 0);
        checkOutput("reset.outValid", int'(bus.out_valid), 0);
        checkOutput("reset.outLast", int'(bus.out_last), 0);
        checkOutput("reset.outData", int'(bus.out_data), 0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("reset.startIgnoredBusy", int'(bus.busy), 0);
        checkOutput("reset.startIgnoredDone", int'(bus.done), 0);

        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            wrEn = 1'b1; wrAddr = 4'(i - 1); wrData = 8'(i);
        end
        @(negedge clk);
        wrEn = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runBurst(vectors[i], $sformatf("vec%0d", i));
        end

        begin : midReset
            int accepted;
            accepted = 0;
            applyStimulus(0, 16);
            bus.out_ready = 1'b1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                bus.start = 1'b0;
                #1;
                if (bus.out_valid && bus.out_ready) accepted++;
                if (accepted == 5) break;
            end
            checkOutput("midrst.reachedWord5", accepted, 5);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkOutput("midrst.busy", int'(bus.busy), 0);
            checkOutput("midrst.outValid", int'(bus.out_valid), 0);
            checkOutput("midrst.ramEn", int'(bus.ram_en), 0);
            checkOutput("midrst.outLast", int'(bus.out_last), 0);
            checkOutput("midrst.done", int'(bus.done), 0);
            runBurst('{0, 3, 0, -1, 5, 3}, "afterRst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
